// File: rtl/cnn_pkg.sv
// Shared CNN datapath types and arithmetic helpers: saturating accumulator add
// and the requantization step used by every layer output path.
package cnn_pkg;

    localparam int IN_W  = 28;
    localparam int OUT_W = 14;

    typedef logic signed [IN_W-1:0]  acc_t;
    typedef logic signed [OUT_W-1:0] sample_t;

    // OUT_W limits expressed at accumulator width; the minimum is the bitwise inverse of the maximum
    localparam acc_t OUT_MAX_EXT = IN_W'((1 << (OUT_W - 1)) - 1);
    localparam acc_t OUT_MIN_EXT = ~OUT_MAX_EXT;

    function automatic acc_t sat_add(input acc_t a, input acc_t b);
        logic signed [IN_W:0] s;
        s = {a[IN_W-1], a} + {b[IN_W-1], b};
        if (s[IN_W] != s[IN_W-1]) begin
            return s[IN_W] ? {1'b1, {(IN_W-1){1'b0}}} : {1'b0, {(IN_W-1){1'b1}}};
        end
        return s[IN_W-1:0];
    endfunction

    function automatic sample_t requant(input acc_t x, input logic relu_en, input int unsigned shift);
        acc_t r;
        acc_t s;
        r = (relu_en && x[IN_W-1]) ? '0 : x;
        s = r >>> shift;
        if (s > OUT_MAX_EXT) begin
            s = OUT_MAX_EXT;
        end else if (s < OUT_MIN_EXT) begin
            s = OUT_MIN_EXT;
        end
        return s[OUT_W-1:0];
    endfunction

endpackage

// File: rtl/adder_tree_result_drain_result_fifo.sv
// Synchronous show-ahead FIFO; the head word is presented whenever not empty
// and reads as zero when empty. A pop on a full FIFO frees room for a same-cycle push.
module result_fifo
    import cnn_pkg::*;
#(
    parameter int DATA_W = OUT_W,
    parameter int DEPTH  = 8
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       i_push,
    input  logic [DATA_W-1:0]          i_data,
    input  logic                       i_pop,
    output logic [DATA_W-1:0]          o_data,
    output logic [$clog2(DEPTH):0]     o_count,
    output logic                       o_full,
    output logic                       o_empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [AW-1:0]     r_wr;
    logic [AW-1:0]     r_rd;
    logic [CW-1:0]     r_count;
    logic              w_pop;
    logic              w_push;

    assign o_full  = (r_count == CW'(DEPTH));
    assign o_empty = (r_count == '0);
    assign o_count = r_count;
    assign o_data  = o_empty ? '0 : r_mem[r_rd];

    assign w_pop  = i_pop & ~o_empty;
    assign w_push = i_push & (~o_full | w_pop);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr    <= '0;
            r_rd    <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_wr <= r_wr + 1'b1;
            end
            if (w_pop) begin
                r_rd <= r_rd + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr] <= i_data;
        end
    end

endmodule

// File: rtl/adder_tree_result_drain.sv
// Drains the pipelined adder tree: tags which tree slots hold real sums, captures
// each once, biases/requantizes it and buffers it behind a credit-guarded stream.
module adder_tree_result_drain
    import cnn_pkg::*;
#(
    parameter int unsigned FRAC_SHIFT = 7,
    parameter int          TREE_LAT   = 3,
    parameter int          FIFO_DEPTH = 8
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          en_adders,
    input  logic                          clear_adders,
    input  logic                          tree_issue,
    input  logic signed [IN_W-1:0]        tree_sum,
    input  logic signed [IN_W-1:0]        bias,
    input  logic                          relu_en,
    output logic                          issue_ok,
    output logic signed [OUT_W-1:0]       out_data,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          overflow
);

    // Enough headroom for every tree slot, the P1 register and a full FIFO
    localparam int OUTS_W = $clog2(FIFO_DEPTH + TREE_LAT + 2) + 1;

    logic [TREE_LAT-1:0]        r_tag;
    logic                       r_taken;
    logic                       w_take;
    logic [TREE_LAT-1:0]        w_tag_live;

    acc_t                       r_sum_p1;
    logic                       r_vld_p1;
    sample_t                    w_data_p2;

    logic                       w_fifo_full;
    logic                       w_fifo_empty;
    logic [$clog2(FIFO_DEPTH):0] w_fifo_count;
    logic [OUT_W-1:0]           w_fifo_data;
    logic                       w_pop;
    logic                       w_drop;
    logic                       r_overflow;
    logic [OUTS_W-1:0]          w_outstanding;

    // The final tree slot may be held for many cycles while en_adders is low;
    // taken keeps that stalled result from being captured twice.
    assign w_take = r_tag[TREE_LAT-1] & ~r_taken;

    always_ff @(posedge clk) begin
        if (reset || clear_adders) begin
            r_tag   <= '0;
            r_taken <= 1'b0;
        end else if (en_adders) begin
            r_tag   <= {r_tag[TREE_LAT-2:0], tree_issue};
            r_taken <= 1'b0;
        end else if (w_take) begin
            r_taken <= 1'b1;
        end
    end

    // ---- P1: bias add on the captured tree sum ----
    always_ff @(posedge clk) begin
        if (reset) begin
            r_vld_p1 <= 1'b0;
        end else begin
            r_vld_p1 <= w_take;
        end
    end

    always_ff @(posedge clk) begin
        if (w_take) begin
            r_sum_p1 <= sat_add(tree_sum, bias);
        end
    end

    // ---- P2: requantize straight into the FIFO write port ----
    assign w_data_p2 = requant(r_sum_p1, relu_en, FRAC_SHIFT);

    assign w_pop  = out_valid & out_ready;
    assign w_drop = r_vld_p1 & w_fifo_full & ~w_pop;

    result_fifo #(
        .DATA_W (OUT_W),
        .DEPTH  (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .i_push  (r_vld_p1),
        .i_data  (w_data_p2),
        .i_pop   (out_ready),
        .o_data  (w_fifo_data),
        .o_count (w_fifo_count),
        .o_full  (w_fifo_full),
        .o_empty (w_fifo_empty)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_overflow <= 1'b0;
        end else if (w_drop) begin
            r_overflow <= 1'b1;
        end
    end

    // Credit: every result that will eventually need a FIFO slot
    assign w_tag_live = r_tag & ~{r_taken, {(TREE_LAT-1){1'b0}}};

    always_comb begin
        w_outstanding = OUTS_W'(r_vld_p1) + OUTS_W'(w_fifo_count);
        for (int k = 0; k < TREE_LAT; k++) begin
            w_outstanding = w_outstanding + OUTS_W'(w_tag_live[k]);
        end
    end

    assign issue_ok   = (w_outstanding < OUTS_W'(FIFO_DEPTH));
    assign out_data   = w_fifo_data;
    assign out_valid  = ~w_fifo_empty;
    assign fifo_count = w_fifo_count;
    assign overflow   = r_overflow;

endmodule

// File: doc/adder_tree_result_drain.md
# adder_tree_result_drain

Consumer end of the 8-input pipelined saturating adder tree. Tracks which tree slots carry real results, since the tree has enable and clear but no valid. Captures each finished 28-bit sum exactly once, then adds bias, applies optional ReLU and requantizes to 14-bit Q-format. Buffers results in a small FIFO behind a valid/ready stream and gives the MAC controller an issue credit signal so in-flight results are never dropped.

## Interface
- IN_W, 28, tree sum / bias width
- OUT_W, 14, output sample width
- FRAC_SHIFT, 7, arithmetic right shift applied during requantization
- TREE_LAT, 3, adder-tree depth in enabled clock edges
- FIFO_DEPTH, 8, output buffer entries (power of two)

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high
- en_adders  in  1  same enable that drives the adder tree
- clear_adders  in  1  same clear that drives the adder tree
- tree_issue  in  1  a new operand set enters the tree this cycle (meaningful only with en_adders=1)
- tree_sum  in  IN_W  tree final-stage output, signed
- bias  in  IN_W  signed bias, static for a layer
- relu_en  in  1  clamp negatives to 0
- issue_ok  out  1  one more tree_issue can be absorbed
- out_data  out  OUT_W  signed result
- out_valid  out  1  out_data holds the FIFO head
- out_ready  in  1  consumer accepts on out_valid & out_ready
- fifo_count  out  $clog2(FIFO_DEPTH)+1  FIFO occupancy
- overflow  out  1  sticky; a result was dropped

## Operation
- Tag shift register tag[TREE_LAT-1:0] mirrors the tree.
  - On an edge with en_adders=1: tag[0] <= tree_issue, tag[k] <= tag[k-1].
  - On an edge with en_adders=0: tag holds.
- take = tag[TREE_LAT-1] & ~taken.
  - taken is set on a take edge and cleared on every edge with en_adders=1.
  - Each result is therefore captured exactly once, even if en_adders stays low indefinitely.
- clear_adders (priority over en_adders): tag and taken are zeroed. Results already in P1/P2/FIFO are kept.
- Stage P1, on a take edge: p1 <= sat_IN_W(tree_sum + bias). Overflow clamps to 0x7FFFFFF or 0x8000000, using the same rule as the tree adders.
- Stage P2:
  - relu_en clamps p1 < 0 to 0.
  - Then arithmetic shift right by FRAC_SHIFT, which floors toward minus infinity.
  - Then saturate to OUT_W, range 0x1FFF..0x2000.
  - The result is written to the FIFO.
- If the FIFO is full at write time, drop the result and set overflow. A simultaneous pop frees the slot, so the write succeeds and nothing is dropped.
- FIFO is show-ahead. Pop happens on out_valid & out_ready. Simultaneous push and pop leaves count unchanged.
- Outstanding = popcount(tag & ~taken mask) + p1_v + p2_v + fifo_count.
  - issue_ok = outstanding < FIFO_DEPTH.
  - tree_issue while issue_ok=0 is still tracked, and may cause overflow.
- Reset values:
  - tag, taken, p1_v, p2_v, fifo_count, out_valid and overflow are 0.
  - out_data is 0.
  - issue_ok is 1.
- Reset mid-operation discards everything, including FIFO contents. overflow clears only on reset.

## Timing
- Issue sampled at edge E0, with en_adders high on every edge. tree_sum is valid after E(TREE_LAT-1)=E2.
- take is high in the cycle after E2; P1 loads at E3; FIFO write at E4; out_valid is high the cycle after E4.
- Issue-to-out_valid latency is TREE_LAT+2 = 5 edges.
- Throughput: one result per cycle with continuous en_adders and out_ready=1.
- Each cycle en_adders is low before the result reaches the final stage delays it by one cycle. Once the result is at the final stage it is taken one cycle later regardless of en_adders.
- issue_ok is combinational from registered state only, with no path from tree_issue.

## Structure
- Shared package cnn_pkg holds:
  - IN_W and OUT_W constants.
  - sat_add function (IN_W saturating add).
  - requant function (relu, shift, saturate to OUT_W), shared with other output paths.
- One sub-module: result_fifo, a synchronous show-ahead FIFO with count, push, pop and full/empty.
- Top level holds the tag/taken tracker, P1/P2 and the credit logic.

## Test plan
- bias=0, relu_en=0, one issue, tree_sum=896 at take -> out_data=7, out_valid rises 5 edges after the issue edge.
- tree_sum=0x7FFFFF0, bias=0x100 -> P1 saturates to 0x7FFFFFF -> out_data=0x1FFF. tree_sum=-1000 with relu_en=0 -> 0x3FF8 (-8); with relu_en=1 -> 0.
- Issue, then hold en_adders low for 4 cycles once tag[2]=1 -> exactly one output, value unchanged.
- out_ready=0, issue every cycle:
  - issue_ok falls once 8 results are outstanding.
  - Exactly 8 outputs drain in order after out_ready=1.
  - overflow stays 0.
- Force a 9th issue while issue_ok=0, with out_ready=0 -> overflow=1 and fifo_count=8.
- Issue 2 sets, assert clear_adders one edge later -> neither is output. Reset asserted while FIFO has 3 entries -> out_valid=0 and fifo_count=0 next cycle.
